llc_plru_engine: RTL and testbench

Replacement-state engine for the 16 MB, 16-way last-level cache. Holds the 15-bit tree pseudo-LRU state for every one of the 16,384 sets and serves touch, victim-query and fill requests from the cache controller. It is the stage directly downstream of the controller's tag lookup: the controller sends the set index and hit way, or asks for a victim, and consumes the way number returned. Pipelined for one request per cycle with same-set forwarding.

---
 rtl/llc_plru_engine.sv | 214 +++++++++++++++++++++
 tb/tb_llc_plru_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_plru_engine.sv
// Tree pseudo-LRU replacement engine for the 16-way LLC: 2-stage read/modify/write pipeline with same-set forwarding.
// Optional per-op counters are built when LLC_PLRU_STATS_EN is defined.
module llc_plru_engine #(
   parameter int NUM_SETS   = 16384,
   parameter int INDEX_BITS = 14,
   parameter int WAYS       = 16,
   parameter int WAY_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [INDEX_BITS-1:0] req_index,
   input  logic [WAY_BITS-1:0]   req_way,
   output logic                  rsp_valid,
   output logic [WAY_BITS-1:0]   rsp_way,
   output logic [WAYS-2:0]       rsp_plru,
   output logic                  init_busy
`ifdef LLC_PLRU_STATS_EN
   ,
   output logic [31:0]           stat_touch,
   output logic [31:0]           stat_fill
`endif
);

   localparam int TREE_BITS = WAYS - 1;
   localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(NUM_SETS - 1);

   typedef enum logic [1:0] {
      OP_TOUCH  = 2'b00,
      OP_VICTIM = 2'b01,
      OP_FILL   = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   // Follow the bits from the root; each direction taken becomes the next way bit, MSB first.
   function automatic logic [WAY_BITS-1:0] plru_victim(input logic [TREE_BITS-1:0] bits);
      logic [3:0]          node;
      logic                dir;
      logic [WAY_BITS-1:0] way;
      node = '0;
      way  = '0;
      for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
         dir  = bits[node];
         way  = {way[WAY_BITS-2:0], dir};
         node = {node[2:0], 1'b0} + 4'd1 + {3'b000, dir};
      end
      return way;
   endfunction

   // Point every node on the way's path away from it.
   function automatic logic [TREE_BITS-1:0] plru_touch(input logic [TREE_BITS-1:0] bits,
                                                       input logic [WAY_BITS-1:0]  way);
      logic [3:0]          node;
      logic                dir;
      logic [WAY_BITS-1:0] rem;
      logic [TREE_BITS-1:0] nb;
      nb   = bits;
      node = '0;
      rem  = way;
      for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
         dir      = rem[WAY_BITS-1];
         rem      = {rem[WAY_BITS-2:0], 1'b0};
         nb[node] = ~dir;
         node     = {node[2:0], 1'b0} + 4'd1 + {3'b000, dir};
      end
      return nb;
   endfunction

   state_e                state_q, state_n;
   logic [INDEX_BITS-1:0] init_cnt;

   logic                  accept;
   logic                  fwd_hit;

   logic                  s2_valid;
   op_e                   s2_op;
   logic [INDEX_BITS-1:0] s2_index;
   logic [WAY_BITS-1:0]   s2_way;
   logic                  s2_fwd;
   logic [TREE_BITS-1:0]  s2_fwd_bits;
   logic [TREE_BITS-1:0]  rd_data;

   logic [TREE_BITS-1:0]  base_bits;
   logic [TREE_BITS-1:0]  new_bits;
   logic [WAY_BITS-1:0]   victim_way;
   logic [WAY_BITS-1:0]   out_way;

   logic                  mem_we;
   logic [INDEX_BITS-1:0] mem_waddr;
   logic [TREE_BITS-1:0]  mem_wdata;

   // NOTE: the array has no reset; the init sequence clears it one index per cycle instead.
   logic [TREE_BITS-1:0]  mem [NUM_SETS];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state_q <= state_n;
         if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_n   = state_q;
      init_busy = 1'b0;
      req_ready = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_busy = 1'b1;
            if (init_cnt == LAST_INDEX) state_n = ST_RUN;
         end
         ST_RUN: begin
            req_ready = ~rst;
         end
         default: state_n = ST_INIT;
      endcase
   end

   assign accept  = req_valid & req_ready;
   assign fwd_hit = s2_valid && (s2_index == req_index);

   // Stage 2 modify: forwarded bits replace array data when the previous request hit the same set.
   always_comb begin
      base_bits  = s2_fwd ? s2_fwd_bits : rd_data;
      victim_way = plru_victim(base_bits);
      new_bits   = base_bits;
      out_way    = '0;
      case (s2_op)
         OP_TOUCH: begin
            new_bits = plru_touch(base_bits, s2_way);
            out_way  = s2_way;
         end
         OP_VICTIM: out_way = victim_way;
         OP_FILL: begin
            new_bits = plru_touch(base_bits, victim_way);
            out_way  = victim_way;
         end
         default: out_way = '0;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = s2_index;
      mem_wdata = new_bits;
      if (state_q == ST_INIT) begin
         mem_we    = ~rst;
         mem_waddr = init_cnt;
         mem_wdata = '0;
      end else if (s2_valid && !rst && (s2_op == OP_TOUCH || s2_op == OP_FILL)) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data <= mem[req_index];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_way   <= '0;
         rsp_plru  <= '0;
      end else begin
         s2_valid  <= accept;
         rsp_valid <= s2_valid;
         if (s2_valid) begin
            rsp_way  <= out_way;
            rsp_plru <= new_bits;
         end
      end
   end

   // Pipeline payload only matters while its valid bit is set, so it carries no reset.
   always_ff @(posedge clk) begin
      s2_op       <= op_e'(req_op);
      s2_index    <= req_index;
      s2_way      <= req_way;
      s2_fwd      <= accept && fwd_hit;
      s2_fwd_bits <= new_bits;
   end

`ifdef LLC_PLRU_STATS_EN
   logic [31:0] stat_touch_q;
   logic [31:0] stat_fill_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_touch_q <= '0;
         stat_fill_q  <= '0;
      end else begin
         if (accept && op_e'(req_op) == OP_TOUCH && stat_touch_q != '1) stat_touch_q <= stat_touch_q + 1'b1;
         if (accept && op_e'(req_op) == OP_FILL && stat_fill_q != '1) stat_fill_q <= stat_fill_q + 1'b1;
      end
   end

   assign stat_touch = stat_touch_q;
   assign stat_fill  = stat_fill_q;
`endif

endmodule

// File: tb/tb_llc_plru_engine.sv
// Self-checking bench for llc_plru_engine: directed scenarios plus random traffic against a serial
// PLRU model built from per-way path arithmetic.
module tb_llc_plru_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [13:0] req_index;
   logic [3:0]  req_way;
   logic        rsp_valid;
   logic [3:0]  rsp_way;
   logic [14:0] rsp_plru;
   logic        init_busy;
`ifdef LLC_PLRU_STATS_EN
   logic [31:0] stat_touch;
   logic [31:0] stat_fill;
`endif

   llc_plru_engine dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_index (req_index),
      .req_way   (req_way),
      .rsp_valid (rsp_valid),
      .rsp_way   (rsp_way),
      .rsp_plru  (rsp_plru),
      .init_busy (init_busy)
`ifdef LLC_PLRU_STATS_EN
      ,
      .stat_touch(stat_touch),
      .stat_fill (stat_fill)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [3:0]  way;
      logic [14:0] plru;
   } exp_t;

   exp_t        expq[$];
   logic [14:0] model [16384];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          n_touch = 0;
   int          n_fill = 0;
   logic        chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Node on level l of way w's path is (2^l - 1) + (w >> (4-l)); w's direction there is bit (3-l).
   function automatic int path_node(input int w, input int l);
      return ((1 << l) - 1) + (w >> (4 - l));
   endfunction

   function automatic int path_dir(input int w, input int l);
      return (w >> (3 - l)) & 1;
   endfunction

   // The victim is the unique way whose whole path is pointed at by the bits.
   function automatic int m_victim(input logic [14:0] bits);
      int found;
      found = -1;
      for (int w = 15; w >= 0; w--) begin
         int ok;
         ok = 1;
         for (int l = 0; l < 4; l++)
            if (((bits >> path_node(w, l)) & 15'd1) != 15'(path_dir(w, l))) ok = 0;
         if (ok == 1) found = w;
      end
      return found;
   endfunction

   function automatic logic [14:0] m_mru(input logic [14:0] bits, input int w);
      logic [14:0] nb;
      nb = bits;
      for (int l = 0; l < 4; l++) begin
         if (path_dir(w, l) == 1) nb = nb & ~(15'd1 << path_node(w, l));
         else                     nb = nb |  (15'd1 << path_node(w, l));
      end
      return nb;
   endfunction

   // Drive one request for one cycle and queue the serially computed response.
   // kway/kplru >= 0 substitute a known answer for the model's value.
   task automatic issue(input int op, input int idx, input int way, input int kway, input int kplru);
      exp_t        e;
      logic [14:0] cur;
      int          w;
      @(negedge clk);
      check("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = 2'(op);
      req_index = 14'(idx);
      req_way   = 4'(way);
      cur = model[idx];
      case (op)
         0: begin cur = m_mru(cur, way); w = way; n_touch++; end
         1: w = m_victim(cur);
         2: begin w = m_victim(cur); cur = m_mru(cur, w); n_fill++; end
         default: w = 0;
      endcase
      model[idx] = cur;
      e.due  = cyc + 2;
      e.way  = (kway >= 0) ? 4'(kway) : 4'(w);
      e.plru = (kplru >= 0) ? 15'(kplru) : cur;
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_init(input string tag);
      int cnt;
      int ready_high;
      cnt = 0;
      ready_high = 0;
      while (init_busy === 1'b1 && cnt < 20000) begin
         if (req_ready !== 1'b0) ready_high++;
         cnt++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, cnt, 16384);
      check({tag, "_ready_while_busy"}, ready_high, 0);
      check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_v;
         exp_t e;
         while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
         exp_v = (expq.size() > 0) && (expq[0].due == cyc);
         check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
         if (exp_v) begin
            e = expq.pop_front();
            check("rsp_way", {28'd0, rsp_way}, {28'd0, e.way});
            check("rsp_plru", {17'd0, rsp_plru}, {17'd0, e.plru});
         end
      end
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 2'd0;
      req_index = '0;
      req_way = '0;
      for (int i = 0; i < 16384; i++) model[i] = '0;

      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_init_busy", {31'd0, init_busy}, 32'd1);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_way", {28'd0, rsp_way}, 32'd0);
      check("rst_rsp_plru", {17'd0, rsp_plru}, 32'd0);
      rst = 1'b0;
      wait_init("init");

      issue(1, 100, 0, 0, 0);
      idle(3);

      issue(0, 5, 0, 0, 15'h008B);
      issue(1, 5, 0, 8, 15'h008B);
      idle(3);

      begin
         int fill_order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
         for (int i = 0; i < 16; i++) issue(2, 7, 0, fill_order[i], -1);
      end
      idle(3);

      issue(0, 3, 5, 5, -1);
      issue(2, 3, 0, -1, -1);
      issue(1, 3, 0, -1, -1);
      idle(3);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) idle(1);
         else issue(int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(15)), -1, -1);
      end
      idle(4);
      check("queue_drained_random", expq.size(), 0);

      issue(0, 9, 3, -1, -1);
      issue(2, 9, 0, -1, -1);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
      @(negedge clk);
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
      check("midrst_init_busy", {31'd0, init_busy}, 32'd1);
      check("midrst_rsp_way", {28'd0, rsp_way}, 32'd0);
      check("midrst_rsp_plru", {17'd0, rsp_plru}, 32'd0);
      for (int i = 0; i < 16384; i++) model[i] = '0;
      n_touch = 0;
      n_fill = 0;
      rst = 1'b0;
      wait_init("reinit");

      issue(1, 9, 0, 0, 0);
      idle(3);

`ifdef LLC_PLRU_STATS_EN
      issue(0, 20, 1, -1, -1);
      issue(1, 20, 0, -1, -1);
      issue(2, 21, 0, -1, -1);
      issue(0, 20, 9, -1, -1);
      issue(1, 21, 0, -1, -1);
      issue(1, 22, 0, -1, -1);
      issue(2, 20, 0, -1, -1);
      issue(0, 23, 4, -1, -1);
      issue(1, 23, 0, -1, -1);
      idle(3);
      check("stat_touch", stat_touch, 32'd3);
      check("stat_fill", stat_fill, 32'd2);
      @(negedge clk);
      dut.stat_fill_q = 32'hFFFF_FFFE;
      issue(2, 30, 0, -1, -1);
      issue(2, 30, 0, -1, -1);
      issue(2, 30, 0, -1, -1);
      idle(3);
      check("stat_fill_saturate", stat_fill, 32'hFFFF_FFFF);
      check("stat_touch_hold", stat_touch, 32'd3);
`endif

      idle(4);
      check("queue_drained_final", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
